// File: rtl/sensor_scheduler.sv
// -----------------------------------------------------------------------------
// sensor_scheduler
//
// Periodically sequences the HC-SR04 distance controller and the DHT11
// temperature/humidity controller through start/done handshakes. Only one
// sensor runs at a time, and DHT11 wins when both are due. The latest results
// are latched, and one of them is driven to the FND driver, chosen by mode.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   mode[1:0]  display select: 00 distance, 01 temperature, 10 humidity,
//              11 hold (or auto-scan when AUTO_SCAN_EN is defined)
//   us_start   one-cycle start pulse to the HC-SR04 controller
//   us_done    one-cycle pulse, us_dist valid
//   us_dist    distance in cm, 0..400
//   dht_start  one-cycle start pulse to the DHT11 controller
//   dht_done   one-cycle pulse, frame received
//   dht_valid  checksum OK, sampled with dht_done
//   dht_temp   temperature in degrees C
//   dht_humi   humidity in %RH
//   fnd_value  registered binary value 0..9999 for the FND driver
//   busy       high in every state except IDLE
//   err[1:0]   bit0 HC-SR04 timeout; bit1 DHT11 timeout or checksum fail
//
// Build option:
//   AUTO_SCAN_EN  when defined, mode 11 rotates the display through
//                 distance -> temperature -> humidity every ROTATE_CYC cycles.
//                 When undefined, mode 11 freezes fnd_value and no rotation
//                 counter exists.
// -----------------------------------------------------------------------------
module sensor_scheduler #(
   parameter int US_PERIOD_CYC  = 10_000_000,
   parameter int DHT_PERIOD_CYC = 200_000_000,
   parameter int TIMEOUT_CYC    = 50_000_000,
   parameter int ROTATE_CYC     = 300_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  mode,
   output logic        us_start,
   input  logic        us_done,
   input  logic [8:0]  us_dist,
   output logic        dht_start,
   input  logic        dht_done,
   input  logic        dht_valid,
   input  logic [7:0]  dht_temp,
   input  logic [7:0]  dht_humi,
   output logic [13:0] fnd_value,
   output logic        busy,
   output logic [1:0]  err
);

   // Catch nonsensical parameter overrides at elaboration time.
   if (US_PERIOD_CYC < 2 || DHT_PERIOD_CYC < 2 || TIMEOUT_CYC < 2 || ROTATE_CYC < 2)
   begin : g_param_check
      $error("sensor_scheduler: all cycle-count parameters must be >= 2");
   end

   localparam int US_W  = $clog2(US_PERIOD_CYC);
   localparam int DHT_W = $clog2(DHT_PERIOD_CYC);
   localparam int TO_W  = $clog2(TIMEOUT_CYC);

   localparam logic [US_W-1:0]  US_LAST  = US_W'(US_PERIOD_CYC - 1);
   localparam logic [DHT_W-1:0] DHT_LAST = DHT_W'(DHT_PERIOD_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_DHT_START = 3'd1;
   localparam logic [2:0] ST_DHT_WAIT  = 3'd2;
   localparam logic [2:0] ST_US_START  = 3'd3;
   localparam logic [2:0] ST_US_WAIT   = 3'd4;

   logic [2:0]       state_reg, state_next;
   logic [US_W-1:0]  us_tmr_reg;
   logic [DHT_W-1:0] dht_tmr_reg;
   logic [TO_W-1:0]  to_cnt_reg;
   logic             us_pend_reg, dht_pend_reg;
   logic [8:0]       dist_reg, dist_next;
   logic [7:0]       temp_reg, temp_next;
   logic [7:0]       humi_reg, humi_next;
   logic [1:0]       err_reg, err_next;
   logic [13:0]      fnd_reg, fnd_next;

   logic us_wrap, dht_wrap, timed_out;

   assign us_wrap   = (us_tmr_reg == US_LAST);
   assign dht_wrap  = (dht_tmr_reg == DHT_LAST);
   assign timed_out = (to_cnt_reg == TO_LAST);

   // Free-running period timers; each wrap raises a single (non-counting)
   // request. A wrap coinciding with the START state keeps the flag set so
   // that request is not lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         us_tmr_reg   <= '0;
         dht_tmr_reg  <= '0;
         us_pend_reg  <= 1'b0;
         dht_pend_reg <= 1'b0;
      end else begin
         us_tmr_reg  <= us_wrap  ? '0 : us_tmr_reg + 1'b1;
         dht_tmr_reg <= dht_wrap ? '0 : dht_tmr_reg + 1'b1;
         if (us_wrap)
            us_pend_reg <= 1'b1;
         else if (state_reg == ST_US_START)
            us_pend_reg <= 1'b0;
         if (dht_wrap)
            dht_pend_reg <= 1'b1;
         else if (state_reg == ST_DHT_START)
            dht_pend_reg <= 1'b0;
      end
   end

   // Timeout counter: zeroed in either START state, counts while waiting.
   always_ff @(posedge clk) begin
      if (reset || state_reg == ST_DHT_START || state_reg == ST_US_START)
         to_cnt_reg <= '0;
      else if (state_reg == ST_DHT_WAIT || state_reg == ST_US_WAIT)
         to_cnt_reg <= to_cnt_reg + 1'b1;
   end

   // Sequencer and result latching. A done pulse arriving in the same cycle
   // as the timeout takes precedence; dones outside the matching WAIT state
   // are ignored.
   always_comb begin
      state_next = state_reg;
      dist_next  = dist_reg;
      temp_next  = temp_reg;
      humi_next  = humi_reg;
      err_next   = err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (dht_pend_reg)
               state_next = ST_DHT_START;
            else if (us_pend_reg)
               state_next = ST_US_START;
         end
         ST_DHT_START: state_next = ST_DHT_WAIT;
         ST_DHT_WAIT: begin
            if (dht_done) begin
               if (dht_valid) begin
                  temp_next   = dht_temp;
                  humi_next   = dht_humi;
                  err_next[1] = 1'b0;
               end else begin
                  err_next[1] = 1'b1;
               end
               state_next = ST_IDLE;
            end else if (timed_out) begin
               err_next[1] = 1'b1;
               state_next  = ST_IDLE;
            end
         end
         ST_US_START: state_next = ST_US_WAIT;
         ST_US_WAIT: begin
            if (us_done) begin
               dist_next   = us_dist;
               err_next[0] = 1'b0;
               state_next  = ST_IDLE;
            end else if (timed_out) begin
               err_next[0] = 1'b1;
               state_next  = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

`ifdef AUTO_SCAN_EN
   localparam int ROT_W = $clog2(ROTATE_CYC);
   localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_CYC - 1);

   logic [ROT_W-1:0] rot_cnt_reg;
   logic [1:0]       rot_idx_reg;

   // Held at zero outside mode 11, so every entry into mode 11 starts the
   // rotation from distance.
   always_ff @(posedge clk) begin
      if (reset || mode != 2'b11) begin
         rot_cnt_reg <= '0;
         rot_idx_reg <= 2'd0;
      end else if (rot_cnt_reg == ROT_LAST) begin
         rot_cnt_reg <= '0;
         rot_idx_reg <= (rot_idx_reg == 2'd2) ? 2'd0 : rot_idx_reg + 2'd1;
      end else begin
         rot_cnt_reg <= rot_cnt_reg + 1'b1;
      end
   end
`endif

   // Display selection uses the *_next values so a fresh result reaches the
   // FND one cycle after its done pulse rather than two.
   always_comb begin
      fnd_next = fnd_reg;
      case (mode)
         2'b00: fnd_next = {5'd0, dist_next};
         2'b01: fnd_next = {6'd0, temp_next};
         2'b10: fnd_next = {6'd0, humi_next};
         default: begin
`ifdef AUTO_SCAN_EN
            case (rot_idx_reg)
               2'd0:    fnd_next = {5'd0, dist_next};
               2'd1:    fnd_next = {6'd0, temp_next};
               default: fnd_next = {6'd0, humi_next};
            endcase
`else
            fnd_next = fnd_reg;
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         dist_reg  <= '0;
         temp_reg  <= '0;
         humi_reg  <= '0;
         err_reg   <= '0;
         fnd_reg   <= '0;
      end else begin
         state_reg <= state_next;
         dist_reg  <= dist_next;
         temp_reg  <= temp_next;
         humi_reg  <= humi_next;
         err_reg   <= err_next;
         fnd_reg   <= fnd_next;
      end
   end

   assign us_start  = (state_reg == ST_US_START);
   assign dht_start = (state_reg == ST_DHT_START);
   assign busy      = (state_reg != ST_IDLE);
   assign err       = err_reg;
   assign fnd_value = fnd_reg;

endmodule
